// File: rtl/instr_stream_pkg.sv
// instr_stream_pkg: framing constants and FSM states shared by both ends of the byte-load protocol
package instr_stream_pkg;
    localparam logic [7:0] START_BYTE = 8'hFE;
    localparam logic [7:0] END_BYTE = 8'hFF;
    localparam logic [7:0] ESC_BYTE = 8'h00;
    localparam int BYTES_PER_WORD = 4;
    typedef enum logic [1:0] {IDLE, START, DATA, END} tx_state_e;
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
        return 8'(w >> {~i, 3'b000});
    endfunction
endpackage

// File: rtl/instr_stream_tx.sv
// instr_stream_tx: streams a framed, escaped run of 32-bit words from a source memory, one byte per clock
import instr_stream_pkg::*;
module instr_stream_tx #(
    parameter int AW = 6,
    parameter logic [7:0] IDLE_BYTE = 8'h00
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [AW:0]   num_words_i,
    input  logic          abort_i,
    output logic          src_rd_o,
    output logic [AW-1:0] src_addr_o,
    input  logic [31:0]   src_data_i,
    output logic [7:0]    byte_o,
    output logic          byte_valid_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          ff_sub_o
);
    localparam logic [AW:0] MAX_N = {1'b1, {AW{1'b0}}};
    localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);
    tx_state_e state, state_n;
    logic [AW:0] n, n_start, left, rd_addr;
    logic [1:0] cnt;
    logic [31:0] cur, nxt, word;
    logic [7:0] raw, byte_n;
    logic rd_q;
    assign src_addr_o = rd_addr[AW-1:0];
    assign busy_o = state != IDLE;
    assign byte_valid_o = busy_o;
    assign done_o = state == END;
    // Word 0 is read in the start cycle and bypassed straight in; later words are prefetched into nxt.
    always_comb begin
        n_start = num_words_i > MAX_N ? MAX_N : num_words_i;
        word = state == START ? src_data_i : cnt == LAST ? nxt : cur;
        raw = word_byte(word, state == START ? 2'd0 : cnt + 2'd1);
        state_n = state;
        unique case (state)
            IDLE:    state_n = start_i ? START : IDLE;
            START:   state_n = (abort_i || n == '0) ? END : DATA;
            DATA:    state_n = (abort_i || (cnt == LAST && left == '0)) ? END : DATA;
            default: state_n = IDLE;
        endcase
        byte_n = state_n == START ? START_BYTE :
                 state_n == END   ? END_BYTE :
                 state_n == DATA  ? (raw == END_BYTE ? ESC_BYTE : raw) : IDLE_BYTE;
        src_rd_o = (state == IDLE && start_i && n_start != '0) ||
                   (state == DATA && cnt == 2'd0 && rd_addr < n && !abort_i);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            byte_o <= IDLE_BYTE;
            ff_sub_o <= 1'b0;
            n <= '0;
            left <= '0;
            rd_addr <= '0;
            cnt <= 2'd0;
            cur <= '0;
            nxt <= '0;
            rd_q <= 1'b0;
        end else begin
            state <= state_n;
            byte_o <= byte_n;
            rd_q <= src_rd_o;
            cnt <= state == DATA ? cnt + 2'd1 : 2'd0;
            rd_addr <= state == END ? '0 : src_rd_o ? rd_addr + 1'b1 : rd_addr;
            left <= state == START ? n - 1'b1 : (state == DATA && cnt == LAST) ? left - 1'b1 : left;
            ff_sub_o <= (state == IDLE && start_i) ? 1'b0 : ff_sub_o | (state_n == DATA && raw == END_BYTE);
            if (state == IDLE && start_i)
                n <= n_start;
            if (state == START)
                cur <= src_data_i;
            else if (state == DATA && cnt == LAST)
                cur <= nxt;
            if (state == DATA && rd_q)
                nxt <= src_data_i;
        end
    end
endmodule

// File: tb/tb_instr_stream_tx.sv
// tb_instr_stream_tx: directed frame checks against hand-computed byte streams
module tb_instr_stream_tx;
    localparam int AW = 6;
    logic clk = 1'b0, reset = 1'b1, start_i = 1'b0, abort_i = 1'b0;
    logic [AW:0] num_words_i = '0;
    logic src_rd_o;
    logic [AW-1:0] src_addr_o;
    logic [31:0] src_data_i = '0;
    logic [7:0] byte_o;
    logic byte_valid_o, busy_o, done_o, ff_sub_o;
    logic [31:0] mem [64];
    int rd_total = 0;
    logic [AW-1:0] rd_log [512];
    logic [7:0] got [300];
    logic gv [300], gb [300], gd [300], gf [300];
    int tests = 0, fails = 0;

    instr_stream_tx #(.AW(AW), .IDLE_BYTE(8'h00)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .num_words_i(num_words_i),
        .abort_i(abort_i), .src_rd_o(src_rd_o), .src_addr_o(src_addr_o),
        .src_data_i(src_data_i), .byte_o(byte_o), .byte_valid_o(byte_valid_o),
        .busy_o(busy_o), .done_o(done_o), .ff_sub_o(ff_sub_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (src_rd_o) src_data_i <= mem[src_addr_o];
    always @(negedge clk) begin
        if (src_rd_o && rd_total < 512) begin
            rd_log[rd_total] = src_addr_o;
            rd_total++;
        end
    end

    // Leaves the bench just after the edge that accepted start_i, i.e. in cycle T+1.
    task start_frame(input logic [AW:0] n);
        @(posedge clk); #1;
        start_i = 1'b1;
        num_words_i = n;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    // Entry i of the capture arrays is cycle T+1+i; *_at give the cycle offset from T.
    task collect(input int len, input int abort_at, input int start_at, input int rst_at);
        for (int i = 0; i < len; i++) begin
            abort_i = (i + 1 == abort_at);
            start_i = (i + 1 == start_at);
            reset = (i + 1 == rst_at);
            @(negedge clk);
            got[i] = byte_o;
            gv[i] = byte_valid_o;
            gb[i] = busy_o;
            gd[i] = done_o;
            gf[i] = ff_sub_o;
            @(posedge clk); #1;
        end
        abort_i = 1'b0;
        start_i = 1'b0;
        reset = 1'b0;
    endtask

    task test_reset;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({byte_o, byte_valid_o, busy_o, done_o, ff_sub_o, src_rd_o, src_addr_o} !== 19'd0) begin
            fails++;
            $display("FAIL reset outputs: got %h want 0", {byte_o, byte_valid_o, busy_o, done_o, ff_sub_o, src_rd_o, src_addr_o});
        end
        reset = 1'b0;
    endtask

    task test_basic;
        logic [7:0] exp [11];
        int r0;
        exp = '{8'hFE, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'hB6, 8'hC7, 8'hD8, 8'hFF, 8'h00};
        mem[0] = 32'h11223344;
        mem[1] = 32'hA5B6C7D8;
        r0 = rd_total;
        start_frame(7'd2);
        collect(11, 0, 0, 0);
        for (int i = 0; i < 11; i++) begin
            tests++;
            if (got[i] !== exp[i] || gv[i] !== (i < 10) || gd[i] !== (i == 9)) begin
                fails++;
                $display("FAIL basic byte T+%0d: got %h v%b d%b want %h v%b d%b", i + 1, got[i], gv[i], gd[i], exp[i], i < 10, i == 9);
            end
        end
        tests++;
        if (rd_total - r0 !== 2 || rd_log[r0] !== 6'd0 || rd_log[r0 + 1] !== 6'd1) begin
            fails++;
            $display("FAIL basic reads: got %0d reads, want 2 at addr 0,1", rd_total - r0);
        end
        tests++;
        if (ff_sub_o !== 1'b0) begin
            fails++;
            $display("FAIL basic ff_sub: got %b want 0", ff_sub_o);
        end
    endtask

    task test_empty;
        int r0;
        r0 = rd_total;
        start_frame(7'd0);
        collect(3, 0, 0, 0);
        tests++;
        if ({got[0], got[1], got[2]} !== 24'hFEFF00 || {gd[0], gd[1], gd[2]} !== 3'b010 || {gb[0], gb[1], gb[2]} !== 3'b110) begin
            fails++;
            $display("FAIL empty frame: got %h%h%h d%b%b%b b%b%b%b want FEFF00 d010 b110", got[0], got[1], got[2], gd[0], gd[1], gd[2], gb[0], gb[1], gb[2]);
        end
        tests++;
        if (rd_total != r0) begin
            fails++;
            $display("FAIL empty reads: got %0d want 0", rd_total - r0);
        end
    endtask

    task test_escape;
        logic [7:0] exp [7];
        exp = '{8'hFE, 8'h00, 8'h00, 8'hFE, 8'h00, 8'hFF, 8'h00};
        mem[0] = 32'hFF00FEFF;
        start_frame(7'd1);
        collect(7, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            tests++;
            if (got[i] !== exp[i]) begin
                fails++;
                $display("FAIL escape byte T+%0d: got %h want %h", i + 1, got[i], exp[i]);
            end
        end
        tests++;
        if (ff_sub_o !== 1'b1) begin
            fails++;
            $display("FAIL escape ff_sub after frame: got %b want 1", ff_sub_o);
        end
        mem[0] = 32'h01020304;
        start_frame(7'd1);
        collect(7, 0, 0, 0);
        tests++;
        if (gf[0] !== 1'b0 || ff_sub_o !== 1'b0 || got[1] !== 8'h01 || got[4] !== 8'h04) begin
            fails++;
            $display("FAIL escape ff_sub clear: got %b/%b bytes %h %h want 0/0 01 04", gf[0], ff_sub_o, got[1], got[4]);
        end
    endtask

    task test_full(input logic [AW:0] n_req);
        int r0, bad, badrd;
        for (int i = 0; i < 64; i++) mem[i] = 32'(i) * 32'h01010101;
        r0 = rd_total;
        start_frame(n_req);
        collect(259, 0, 0, 0);
        bad = 0;
        for (int i = 0; i < 259; i++) begin
            if (gv[i] !== (i < 258)) bad++;
            if (i == 0 && got[i] !== 8'hFE) bad++;
            if (i >= 1 && i <= 256 && got[i] !== 8'((i - 1) / 4)) bad++;
            if (i == 257 && (got[i] !== 8'hFF || gd[i] !== 1'b1)) bad++;
            if (i == 258 && got[i] !== 8'h00) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL full n=%0d stream: %0d bad cycles, want 0", n_req, bad);
        end
        badrd = 0;
        for (int j = 0; j < 64; j++) if (rd_log[r0 + j] !== 6'(j)) badrd++;
        tests++;
        if (rd_total - r0 != 64 || badrd != 0) begin
            fails++;
            $display("FAIL full n=%0d reads: got %0d reads %0d out of order, want 64 ascending", n_req, rd_total - r0, badrd);
        end
    endtask

    task test_abort;
        logic [7:0] exp [12];
        int r0;
        exp = '{8'hFE, 8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'hFF, 8'h00, 8'h00, 8'h00};
        mem[0] = 32'h10111213;
        mem[1] = 32'h20212223;
        mem[2] = 32'h30313233;
        mem[3] = 32'h40414243;
        r0 = rd_total;
        start_frame(7'd4);
        collect(12, 8, 4, 0);
        for (int i = 0; i < 12; i++) begin
            tests++;
            if (got[i] !== exp[i] || gv[i] !== (i < 9) || gd[i] !== (i == 8)) begin
                fails++;
                $display("FAIL abort byte T+%0d: got %h v%b d%b want %h v%b d%b", i + 1, got[i], gv[i], gd[i], exp[i], i < 9, i == 8);
            end
        end
        tests++;
        if (rd_total - r0 != 3 || rd_log[r0 + 2] !== 6'd2) begin
            fails++;
            $display("FAIL abort reads: got %0d want 3 ending at addr 2", rd_total - r0);
        end
    endtask

    task test_reset_mid;
        mem[0] = 32'hC0C1C2C3;
        mem[1] = 32'hD0D1D2D3;
        mem[2] = 32'hE0E1E2E3;
        start_frame(7'd3);
        collect(6, 0, 0, 5);
        tests++;
        if (got[4] !== 8'h00 || gb[4] !== 1'b0 || got[5] !== 8'h00 || gd[4] !== 1'b0) begin
            fails++;
            $display("FAIL reset mid-frame: got %h b%b then %h want 00 b0 then 00", got[4], gb[4], got[5]);
        end
        start_frame(7'd3);
        collect(15, 0, 0, 0);
        tests++;
        if ({got[0], got[1], got[5], got[12], got[13], got[14]} !== 48'hFEC0D0E3FF00 || gd[13] !== 1'b1) begin
            fails++;
            $display("FAIL reset restart frame: got %h %h %h %h %h %h want FE C0 D0 E3 FF 00", got[0], got[1], got[5], got[12], got[13], got[14]);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_empty;
        test_escape;
        test_full(7'd64);
        test_full(7'd100);
        test_abort;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
